// File: rtl/dma_ahb1_resp_router.sv
`default_nettype none
// ============================================================================
//  Module   : dma_ahb1_resp_router
//  Purpose  : Steers AHB1 data-phase responses to the channel that issued the
//             address phase; tracks two-cycle ERROR responses. Per-channel
//             error counters are built when DMA_RESP_ERRCNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module dma_ahb1_resp_router #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 32,
    parameter int RESP_W = 2,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic                       HCLK,
    input  logic                       HRSTn,
    input  logic [CH_W-1:0]            ch_select,
    input  logic [1:0]                 htrans_in,
    input  logic                       hready_in,
    input  logic [DATA_W-1:0]          hrdata_in,
    input  logic [RESP_W-1:0]          hresp_in,
    output logic [NUM_CH*DATA_W-1:0]   rdata_ch,
    output logic [NUM_CH*RESP_W-1:0]   resp_ch,
    output logic [NUM_CH-1:0]          rdy_ch,
    output logic                       dphase_valid,
    output logic [CH_W-1:0]            dphase_ch,
    output logic [NUM_CH-1:0]          err_pulse,
    output logic                       illegal_sel,
    input  logic [NUM_CH-1:0]          errclr,
    output logic [NUM_CH*8-1:0]        errcnt
);

    localparam logic [RESP_W-1:0] c_resp_error = RESP_W'(1);
    localparam logic [CH_W:0]     c_num_ch     = (CH_W+1)'(NUM_CH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR1 = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CH_W-1:0]     r_dphase_ch;
    logic [NUM_CH-1:0]   r_err_pulse;
    logic                r_illegal_sel;

    logic                w_accept;
    logic                w_sel_legal;
    logic                w_accept_ok;
    logic                w_valid;
    logic                w_err_done;
    logic [NUM_CH-1:0]   w_err_vec;

    assign w_accept    = hready_in & htrans_in[1];
    assign w_sel_legal = ({1'b0, ch_select} < c_num_ch);
    assign w_accept_ok = w_accept & w_sel_legal;
    assign w_valid     = (r_state != S_IDLE);
    assign w_err_done  = w_valid & hready_in & (hresp_in == c_resp_error);

    always_ff @(posedge HCLK or negedge HRSTn) begin
        if (!HRSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept_ok) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (!hready_in) begin
                    if (hresp_in == c_resp_error) w_state_nxt = S_ERR1;
                end else begin
                    w_state_nxt = w_accept_ok ? S_DATA : S_IDLE;
                end
            end
            S_ERR1: begin
                // Second ERROR cycle completes the transfer like any other data phase
                if (hready_in) w_state_nxt = w_accept_ok ? S_DATA : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRSTn) begin
        if (!HRSTn) begin
            r_dphase_ch   <= '0;
            r_err_pulse   <= '0;
            r_illegal_sel <= 1'b0;
        end else begin
            if (w_accept_ok) r_dphase_ch <= ch_select;
            r_err_pulse   <= w_err_vec;
            r_illegal_sel <= w_accept & ~w_sel_legal;
        end
    end

    always_comb begin
        w_err_vec = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_err_vec[k] = w_err_done && (r_dphase_ch == CH_W'(k));
        end
    end

    // The owner is taken from the registered data-phase state, never ch_select
    always_comb begin
        rdata_ch = '0;
        resp_ch  = '0;
        rdy_ch   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_valid) begin
                if (r_dphase_ch == CH_W'(k)) begin
                    rdata_ch[k*DATA_W +: DATA_W] = hrdata_in;
                    resp_ch[k*RESP_W +: RESP_W]  = hresp_in;
                    rdy_ch[k]                    = hready_in;
                end
            end else if (ch_select == CH_W'(k)) begin
                rdy_ch[k] = hready_in;
            end
        end
    end

    assign dphase_valid = w_valid;
    assign dphase_ch    = r_dphase_ch;
    assign err_pulse    = r_err_pulse;
    assign illegal_sel  = r_illegal_sel;

`ifdef DMA_RESP_ERRCNT_EN
    logic w_unused_bits;
    assign w_unused_bits = htrans_in[0];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_errcnt
        logic [7:0] r_cnt;
        always_ff @(posedge HCLK or negedge HRSTn) begin
            if (!HRSTn) begin
                r_cnt <= 8'd0;
            end else if (errclr[k]) begin
                r_cnt <= 8'd0;
            end else if (w_err_vec[k] && (r_cnt != 8'hFF)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
        assign errcnt[k*8 +: 8] = r_cnt;
    end
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{errclr, htrans_in[0]};
    assign errcnt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dma_ahb1_resp_router.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dma_ahb1_resp_router
//  Purpose  : Self-checking bench: an 8-channel and a 6-channel router share
//             stimulus and are compared against a transfer-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dma_ahb1_resp_router;

`ifdef DMA_RESP_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [2:0]  ch_select;
    logic [1:0]  htrans;
    logic        hready;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic [7:0]  errclr;

    logic [8*32-1:0] rdata8;
    logic [8*2-1:0]  resp8;
    logic [7:0]      rdy8;
    logic            valid8;
    logic [2:0]      dch8;
    logic [7:0]      epulse8;
    logic            ill8;
    logic [8*8-1:0]  ecnt8;

    logic [6*32-1:0] rdata6;
    logic [6*2-1:0]  resp6;
    logic [5:0]      rdy6;
    logic            valid6;
    logic [2:0]      dch6;
    logic [5:0]      epulse6;
    logic            ill6;
    logic [6*8-1:0]  ecnt6;

    int n_checks = 0;
    int n_errors = 0;

    dma_ahb1_resp_router #(.NUM_CH(8)) dut8 (
        .HCLK(clk), .HRSTn(rst_n), .ch_select(ch_select), .htrans_in(htrans),
        .hready_in(hready), .hrdata_in(hrdata), .hresp_in(hresp),
        .rdata_ch(rdata8), .resp_ch(resp8), .rdy_ch(rdy8),
        .dphase_valid(valid8), .dphase_ch(dch8), .err_pulse(epulse8),
        .illegal_sel(ill8), .errclr(errclr), .errcnt(ecnt8)
    );

    dma_ahb1_resp_router #(.NUM_CH(6)) dut6 (
        .HCLK(clk), .HRSTn(rst_n), .ch_select(ch_select), .htrans_in(htrans),
        .hready_in(hready), .hrdata_in(hrdata), .hresp_in(hresp),
        .rdata_ch(rdata6), .resp_ch(resp6), .rdy_ch(rdy6),
        .dphase_valid(valid6), .dphase_ch(dch6), .err_pulse(epulse6),
        .illegal_sel(ill6), .errclr(errclr[5:0]), .errcnt(ecnt6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transfer-level model: who owns the outstanding data phase, and what happened last cycle
    int          nch [2] = '{8, 6};
    logic        m_valid [2];
    logic [2:0]  m_ch    [2];
    logic [15:0] m_pulse [2];
    logic        m_ill   [2];
    int          m_cnt   [2][16];
    logic        m_acc;
    logic        m_err;
    assign m_acc = hready && htrans[1];
    assign m_err = hready && (hresp == 2'b01);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_valid[i] <= 1'b0;
                m_ch[i]    <= 3'd0;
                m_pulse[i] <= 16'd0;
                m_ill[i]   <= 1'b0;
                for (int k = 0; k < 16; k++) m_cnt[i][k] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_ill[i]   <= m_acc && !(ch_select < nch[i]);
                m_pulse[i] <= (m_valid[i] && m_err) ? (16'd1 << m_ch[i]) : 16'd0;
                for (int k = 0; k < nch[i]; k++) begin
                    if (errclr[k])
                        m_cnt[i][k] <= 0;
                    else if (m_valid[i] && m_err && (m_ch[i] == k) && (m_cnt[i][k] < 255))
                        m_cnt[i][k] <= m_cnt[i][k] + 1;
                end
                if (m_acc && (ch_select < nch[i])) begin
                    m_valid[i] <= 1'b1;
                    m_ch[i]    <= ch_select;
                end else if (hready) begin
                    m_valid[i] <= 1'b0;
                end
            end
        end
    end

    // {rdy, resp, rdata} expected on channel k of instance i
    function automatic logic [63:0] exp_route(input int i, input int k);
        if (m_valid[i])
            return (m_ch[i] == k) ? {29'd0, hready, hresp, hrdata} : 64'd0;
        else
            return ((ch_select < nch[i]) && (ch_select == k)) ? {29'd0, hready, 34'd0} : 64'd0;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 8; k++) begin
            check($sformatf("route8_ch%0d", k), {29'd0, rdy8[k], resp8[2*k +: 2], rdata8[32*k +: 32]}, exp_route(0, k));
            check($sformatf("errcnt8_ch%0d", k), ecnt8[8*k +: 8], CNT_EN ? 64'(m_cnt[0][k]) : 64'd0);
        end
        for (int k = 0; k < 6; k++) begin
            check($sformatf("route6_ch%0d", k), {29'd0, rdy6[k], resp6[2*k +: 2], rdata6[32*k +: 32]}, exp_route(1, k));
            check($sformatf("errcnt6_ch%0d", k), ecnt6[8*k +: 8], CNT_EN ? 64'(m_cnt[1][k]) : 64'd0);
        end
        check("valid8", valid8, m_valid[0]);
        check("valid6", valid6, m_valid[1]);
        if (m_valid[0]) check("dch8", dch8, m_ch[0]);
        if (m_valid[1]) check("dch6", dch6, m_ch[1]);
        check("epulse8", epulse8, m_pulse[0][7:0]);
        check("epulse6", epulse6, m_pulse[1][5:0]);
        check("ill8", ill8, m_ill[0]);
        check("ill6", ill6, m_ill[1]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; ch_select = 3'd0; htrans = 2'b00; hready = 1'b1;
        hrdata = 32'd0; hresp = 2'b00; errclr = 8'd0;
        repeat (3) step();
        rst_n = 1'b1;
        settle();
        check("rst_valid8", valid8, 1'b0);
        check("rst_dch8", dch8, 3'd0);
        check("rst_ecnt8", ecnt8, 64'd0);
        check("rst_rdy8", rdy8, 8'b0000_0001);

        // Owner captured at address phase; ch_select moves on during the data phase
        step(); ch_select = 3'd3; htrans = 2'b10; hready = 1'b1;
        step(); ch_select = 3'd5; htrans = 2'b00; hrdata = 32'hDEADBEEF;
        settle();
        check("t1_rdata3", rdata8[3*32 +: 32], 32'hDEADBEEF);
        check("t1_rdy3", rdy8[3], 1'b1);
        check("t1_rdata5", rdata8[5*32 +: 32], 32'd0);
        check("t1_rdy5", rdy8[5], 1'b0);

        // Back-to-back ch1 then ch6, zero wait states
        step(); ch_select = 3'd1; htrans = 2'b10; hrdata = 32'd0;
        step(); ch_select = 3'd6; htrans = 2'b10; hrdata = 32'h11111111;
        settle();
        check("t2_dch_first", dch8, 3'd1);
        check("t2_rdata1", rdata8[1*32 +: 32], 32'h11111111);
        check("t2_rdata6_idle", rdata8[6*32 +: 32], 32'd0);
        step(); ch_select = 3'd0; htrans = 2'b00; hrdata = 32'h66666666;
        settle();
        check("t2_dch_second", dch8, 3'd6);
        check("t2_rdata6", rdata8[6*32 +: 32], 32'h66666666);
        check("t2_rdata1_off", rdata8[1*32 +: 32], 32'd0);

        // Two-cycle ERROR on ch2
        step(); ch_select = 3'd2; htrans = 2'b10; hready = 1'b1; hrdata = 32'd0;
        step(); ch_select = 3'd0; htrans = 2'b00; hready = 1'b0; hresp = 2'b01;
        settle();
        check("t3_rdy2_wait", rdy8[2], 1'b0);
        step(); hready = 1'b1; hresp = 2'b01;
        settle();
        check("t3_no_pulse_yet", epulse8, 8'd0);
        step(); hresp = 2'b00;
        settle();
        check("t3_pulse", epulse8, 8'b0000_0100);
        check("t3_errcnt2", ecnt8[2*8 +: 8], CNT_EN ? 8'd1 : 8'd0);
        step();
        settle();
        check("t3_pulse_once", epulse8, 8'd0);

        // 256 errors on ch0, pipelined back to back, then clear against a new error
        step(); ch_select = 3'd0; htrans = 2'b10; hready = 1'b1;
        for (int n = 0; n < 256; n++) begin
            step(); htrans = 2'b00; hready = 1'b0; hresp = 2'b01;
            step(); htrans = 2'b10; hready = 1'b1; hresp = 2'b01;
        end
        step(); htrans = 2'b00; hready = 1'b0; hresp = 2'b01;
        settle();
        check("t4_sat", ecnt8[7:0], CNT_EN ? 8'd255 : 8'd0);
        step(); hready = 1'b1; errclr = 8'b0000_0001;
        step(); hresp = 2'b00; errclr = 8'd0;
        settle();
        check("t4_clr_wins", ecnt8[7:0], 8'd0);
        check("t4_pulse", epulse8, 8'b0000_0001);

        // ch_select=7 is illegal only on the 6-channel instance
        step(); ch_select = 3'd7; htrans = 2'b10; hready = 1'b1;
        step(); ch_select = 3'd0; htrans = 2'b00; hrdata = 32'hA5A5A5A5;
        settle();
        check("t5_ill6", ill6, 1'b1);
        check("t5_valid6", valid6, 1'b0);
        check("t5_rdata6_all", rdata6, 192'd0);
        check("t5_ill8", ill8, 1'b0);
        check("t5_rdata8_7", rdata8[7*32 +: 32], 32'hA5A5A5A5);
        step();
        settle();
        check("t5_ill6_once", ill6, 1'b0);

        // Reset dropped with a stalled data phase on ch4
        step(); ch_select = 3'd4; htrans = 2'b10; hready = 1'b1;
        step(); ch_select = 3'd1; htrans = 2'b00; hready = 1'b0;
        #1;
        check("t6_open", valid8, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_valid_async", valid8, 1'b0);
        hready = 1'b1;
        #1;
        check("t6_rdy8", rdy8, 8'b0000_0010);
        check("t6_rdata8", rdata8, 256'd0);
        step(); step();
        rst_n = 1'b1;
        settle();
        check("t6_ecnt_cleared", ecnt8, 64'd0);

        // Mixed traffic, checked cycle by cycle against the model
        for (int n = 0; n < 300; n++) begin
            step();
            ch_select = 3'($urandom_range(0, 7));
            htrans    = 2'($urandom_range(0, 3));
            hready    = ($urandom_range(0, 3) != 0);
            hrdata    = $urandom;
            hresp     = ($urandom_range(0, 2) == 0) ? 2'b01 : 2'b00;
            errclr    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'd0;
        end
        step();
        settle();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dma_ahb1_resp_router.md
# dma_ahb1_resp_router

Parametrised, pipeline-aware AHB1 response router for the DMA channel slice. It sits between the shared AHB1 master port and the per-channel DMA/bridge response inputs. It captures the issuing channel at each address phase and steers the subsequent data-phase response (HRDATA, HRESP, HREADY) to that channel only, even if the channel select has already moved on. It also tracks two-cycle ERROR responses and optionally keeps per-channel error counters.

## Interface

Parameters:

- NUM_CH, 8, number of DMA channels (2..16)
- DATA_W, 32, AHB data width
- RESP_W, 2, AHB HRESP width
- CH_W, $clog2(NUM_CH), channel index width (derived; never overridden)

Ports:

- HCLK  in  1  system clock, rising edge
- HRSTn  in  1  asynchronous active-low reset
- ch_select  in  CH_W  channel currently driving the AHB1 address phase
- htrans_in  in  2  HTRANS of the AHB1 master port
- hready_in  in  1  HREADY returned on AHB1
- hrdata_in  in  DATA_W  HRDATA returned on AHB1
- hresp_in  in  RESP_W  HRESP returned on AHB1
- rdata_ch  out  NUM_CH*DATA_W  per-channel read data, channel k at [k*DATA_W +: DATA_W]
- resp_ch  out  NUM_CH*RESP_W  per-channel response
- rdy_ch  out  NUM_CH  per-channel ready
- dphase_valid  out  1  a data phase is outstanding
- dphase_ch  out  CH_W  owner of the outstanding data phase
- err_pulse  out  NUM_CH  one-cycle pulse on the completing cycle of an ERROR response
- illegal_sel  out  1  one-cycle pulse when an address phase is issued with ch_select >= NUM_CH
- errclr  in  NUM_CH  per-channel error counter clear
- errcnt  out  NUM_CH*8  per-channel saturating error count

## Operation

- Address phase accepted when hready_in=1 and htrans_in[1]=1 (NONSEQ/SEQ). IDLE and BUSY never open a data phase.
- On acceptance with a legal ch_select: dphase_valid<=1 and dphase_ch<=ch_select.
- On acceptance with an illegal ch_select: illegal_sel pulses and dphase_valid<=0. The following data phase is routed to no channel.
- Data phase completes when hready_in=1.
  - With no simultaneous acceptance, dphase_valid<=0.
  - A back-to-back acceptance in the same cycle reloads dphase_ch with the new owner.
- Routing (combinational from registered state):
  - While dphase_valid=1, only channel dphase_ch gets rdata=hrdata_in, resp=hresp_in and rdy=hready_in.
  - While dphase_valid=0, only channel ch_select (if legal) gets rdy=hready_in, with rdata=0 and resp=0.
  - All other channels read zero.
- State machine:
  - IDLE: no data phase. Goes to DATA on acceptance.
  - DATA: goes to ERR1 on hresp_in=ERROR(2'b01) with hready_in=0. Goes to IDLE or DATA on completion.
  - ERR1: first ERROR cycle seen. The next cycle must be hready_in=1 with ERROR, which returns to IDLE/DATA per the acceptance rule.
  - In ERR1, hready_in=0 holds ERR1.
- err_pulse[dphase_ch] fires on the cycle with dphase_valid=1, hready_in=1 and hresp_in=ERROR.
- ch_select changes during a data phase never affect routing of that data phase.

## Timing

- Reset (async assert, sync deassert upstream): state IDLE, dphase_valid=0, dphase_ch=0, err_pulse=0, illegal_sel=0, errcnt=0.
  - All routed outputs read 0 except rdy_ch[ch_select]=hready_in.
- Reset asserted mid data phase abandons it immediately. There is no pending routing after release.
- Address accepted at edge t gives dphase_valid=1 in cycle t+1. Response routing is zero-latency combinational from hready_in/hrdata_in/hresp_in.
- err_pulse and illegal_sel are registered one-cycle pulses, one cycle after the triggering cycle.
- errcnt updates on the edge following the err_pulse trigger condition.
  - It saturates at 255.
  - If errclr[k] and an increment hit the same cycle, clear wins and the result is 0.

## Configuration

- DMA_RESP_ERRCNT_EN defined: per-channel 8-bit saturating error counters are built, with errclr honoured.
- DMA_RESP_ERRCNT_EN undefined: no counters are built. The errcnt ports remain, tied to 0, and errclr is ignored. err_pulse is present in both builds.

## Test plan

- Reset, then NONSEQ ch_select=3 with hready_in=1, then ch_select moves to 5; data cycle hrdata_in=0xDEADBEEF. Required: only rdata_ch[3]=0xDEADBEEF, rdy_ch[3]=1, channel 5 reads 0.
- Back-to-back NONSEQ ch 1 then ch 6 with zero wait states. Required: dphase_ch goes 1→6 on consecutive cycles, and each data word lands only on its owner.
- Two-cycle ERROR on ch 2: (hready_in=0, ERROR) then (hready_in=1, ERROR). Required: state passes through ERR1, err_pulse[2] fires once, and errcnt[2] increments by exactly 1.
- With the macro defined: 256 errors on ch 0. Required: errcnt[0]=255. Then errclr[0] coincident with a new error gives errcnt[0]=0.
- NUM_CH=6 with ch_select=7 NONSEQ. Required: illegal_sel pulses, dphase_valid=0, all rdata_ch=0.
- HRSTn dropped with a data phase open on ch 4 and hready_in=0. Required: dphase_valid=0 immediately and rdy_ch[4]=0 unless ch_select=4.
